// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the GPU/CPU memory port arbiter.
//   DEFAULT_MAX_GPU_RUN : default number of back-to-back GPU grants allowed
//                         while the CPU is waiting (starvation guard build)
//   RUN_CNT_W           : width of the starvation run counter (limit 1..15)
//   owner_t             : which requester (if any) got a read grant last cycle
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEFAULT_MAX_GPU_RUN = 4;
    localparam int RUN_CNT_W           = 4;

    // Owner of the read return arriving this cycle, i.e. who was granted a
    // read in the previous cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GPU_RD = 2'd1,
        CPU_RD = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester ports (GPU display engine, MIPS core) and the
// shared single-port RAM port of the memory arbiter.
//   gpu_* / cpu_*  : req, addr, wr_ena, wr_data in; gnt, rd_valid, rd_data out
//   mem_*          : addr, wr_data, wr_ena out; rd_data in (one-cycle latency)
// Modports:
//   slave  : the arbiter itself
//   master : the requesters plus the RAM (the surrounding system)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);

    logic              gpu_req;
    logic [ADDR_W-1:0] gpu_addr;
    logic              gpu_wr_ena;
    logic [31:0]       gpu_wr_data;
    logic              gpu_gnt;
    logic              gpu_rd_valid;
    logic [31:0]       gpu_rd_data;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wr_ena;
    logic [31:0]       cpu_wr_data;
    logic              cpu_gnt;
    logic              cpu_rd_valid;
    logic [31:0]       cpu_rd_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_wr_ena;
    logic [31:0]       mem_rd_data;

    modport slave (
        input  gpu_req, gpu_addr, gpu_wr_ena, gpu_wr_data,
        output gpu_gnt, gpu_rd_valid, gpu_rd_data,
        input  cpu_req, cpu_addr, cpu_wr_ena, cpu_wr_data,
        output cpu_gnt, cpu_rd_valid, cpu_rd_data,
        output mem_addr, mem_wr_data, mem_wr_ena,
        input  mem_rd_data
    );

    modport master (
        output gpu_req, gpu_addr, gpu_wr_ena, gpu_wr_data,
        input  gpu_gnt, gpu_rd_valid, gpu_rd_data,
        output cpu_req, cpu_addr, cpu_wr_ena, cpu_wr_data,
        input  cpu_gnt, cpu_rd_valid, cpu_rd_data,
        input  mem_addr, mem_wr_data, mem_wr_ena,
        output mem_rd_data
    );

endinterface

// File: rtl/arb_run_counter.sv
// ---------------------------------------------------------------------------
// arb_run_counter
// Counts consecutive GPU grants taken while the CPU is kept waiting and flags
// when the allowed run length has been used up.
// Ports:
//   cclk     in  : system clock
//   rstb     in  : asynchronous active-low reset
//   gpu_gnt  in  : GPU granted this cycle
//   cpu_gnt  in  : CPU granted this cycle
//   cpu_req  in  : CPU requesting this cycle
//   at_limit out : run counter has reached MAX_GPU_RUN
// ---------------------------------------------------------------------------
module arb_run_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_GPU_RUN = DEFAULT_MAX_GPU_RUN
) (
    input  logic cclk,
    input  logic rstb,
    input  logic gpu_gnt,
    input  logic cpu_gnt,
    input  logic cpu_req,
    output logic at_limit
);

    localparam logic [RUN_CNT_W-1:0] RUN_LIMIT = RUN_CNT_W'(MAX_GPU_RUN);

    logic [RUN_CNT_W-1:0] run_count;

    // The run only counts GPU grants that actually made the CPU wait; any
    // cycle where the CPU is served or not asking starts a fresh run. The
    // counter saturates so it never wraps past the limit.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            run_count <= '0;
        end else if (cpu_gnt || !cpu_req) begin
            run_count <= '0;
        end else if (gpu_gnt && (run_count != RUN_LIMIT)) begin
            run_count <= run_count + 1'b1;
        end
    end

    assign at_limit = (run_count == RUN_LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port RAM between the GPU display engine and the MIPS
// core. At most one requester is granted per cycle; the GPU wins ties. Read
// data returns one cycle after the grant and is routed to whoever issued the
// read.
// Parameters:
//   MAX_GPU_RUN : consecutive GPU grants allowed while the CPU waits (1..15)
//   ADDR_W      : address width of every address port
// Ports:
//   cclk : system clock, all state on the rising edge
//   rstb : asynchronous active-low reset
//   bus  : mem_port_arbiter_if.slave (GPU port, CPU port, RAM port)
// Build option:
//   ARB_STARVE_GUARD_EN - when defined, a run counter forces a CPU grant
//   after MAX_GPU_RUN back-to-back GPU grants with the CPU waiting;
//   otherwise the GPU has strict priority.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_GPU_RUN = DEFAULT_MAX_GPU_RUN,
    parameter int ADDR_W      = 32
) (
    input  logic              cclk,
    input  logic              rstb,
    mem_port_arbiter_if.slave bus
);

    if ((MAX_GPU_RUN < 1) || (MAX_GPU_RUN > 15)) begin : g_bad_run_limit
        $error("mem_port_arbiter: MAX_GPU_RUN must be in 1..15");
    end

    logic              gpu_gnt_c;
    logic              cpu_gnt_c;
    logic              force_cpu;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wr_data;
    logic              sel_wr_ena;
    logic              gpu_rd_valid_c;
    logic              cpu_rd_valid_c;
    owner_t            state;
    owner_t            state_nxt;

`ifdef ARB_STARVE_GUARD_EN
    arb_run_counter #(
        .MAX_GPU_RUN (MAX_GPU_RUN)
    ) u_run_counter (
        .cclk     (cclk),
        .rstb     (rstb),
        .gpu_gnt  (gpu_gnt_c),
        .cpu_gnt  (cpu_gnt_c),
        .cpu_req  (bus.cpu_req),
        .at_limit (force_cpu)
    );
`else
    assign force_cpu = 1'b0;
`endif

    // Grant decision. The CPU only wins when the GPU is idle or the GPU has
    // used up its run. Grants are gated by rstb so nothing is accepted while
    // the arbiter is held in reset.
    always_comb begin
        gpu_gnt_c = 1'b0;
        cpu_gnt_c = 1'b0;
        if (rstb) begin
            if (bus.cpu_req && (force_cpu || !bus.gpu_req)) begin
                cpu_gnt_c = 1'b1;
            end else if (bus.gpu_req) begin
                gpu_gnt_c = 1'b1;
            end
        end
    end

    // RAM port follows the granted requester in the grant cycle and is
    // parked at zero otherwise.
    always_comb begin
        sel_addr    = '0;
        sel_wr_data = '0;
        sel_wr_ena  = 1'b0;
        if (gpu_gnt_c) begin
            sel_addr    = bus.gpu_addr;
            sel_wr_data = bus.gpu_wr_data;
            sel_wr_ena  = bus.gpu_wr_ena;
        end else if (cpu_gnt_c) begin
            sel_addr    = bus.cpu_addr;
            sel_wr_data = bus.cpu_wr_data;
            sel_wr_ena  = bus.cpu_wr_ena;
        end
    end

    // Owner register: remembers who issued a read last cycle so the RAM's
    // one-cycle-late data can be steered back. Reset drops any read in
    // flight.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next owner is decided purely by this cycle's grant; writes never
    // produce a return.
    always_comb begin
        state_nxt = IDLE;
        if (gpu_gnt_c && !bus.gpu_wr_ena) begin
            state_nxt = GPU_RD;
        end else if (cpu_gnt_c && !bus.cpu_wr_ena) begin
            state_nxt = CPU_RD;
        end
    end

    assign gpu_rd_valid_c = (state == GPU_RD);
    assign cpu_rd_valid_c = (state == CPU_RD);

    assign bus.gpu_gnt      = gpu_gnt_c;
    assign bus.cpu_gnt      = cpu_gnt_c;
    assign bus.mem_addr     = sel_addr;
    assign bus.mem_wr_data  = sel_wr_data;
    assign bus.mem_wr_ena   = sel_wr_ena;
    assign bus.gpu_rd_valid = gpu_rd_valid_c;
    assign bus.cpu_rd_valid = cpu_rd_valid_c;
    assign bus.gpu_rd_data  = gpu_rd_valid_c ? bus.mem_rd_data : 32'h0;
    assign bus.cpu_rd_data  = cpu_rd_valid_c ? bus.mem_rd_data : 32'h0;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_GPU_RUN, default 4: consecutive GPU grants allowed while CPU waits (1..15).
REQ-002 SHALL have parameter ADDR_W, default 32: address width of all address ports.
REQ-003 SHALL have port cclk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rstb  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port gpu_req  input  1  GPU (display) access request.
REQ-006 SHALL have port gpu_addr  input  ADDR_W  GPU byte address.
REQ-007 SHALL have port gpu_wr_ena  input  1  GPU write (1) / read (0).
REQ-008 SHALL have port gpu_wr_data  input  32  GPU write data (frame counter).
REQ-009 SHALL have port gpu_gnt  output  1  GPU access accepted this cycle.
REQ-010 SHALL have port gpu_rd_valid  output  1  gpu_rd_data valid.
REQ-011 SHALL have port gpu_rd_data  output  32  GPU read return.
REQ-012 SHALL have ports cpu_req, cpu_addr, cpu_wr_ena, cpu_wr_data, cpu_gnt, cpu_rd_valid, cpu_rd_data, identical in direction, width and meaning to the gpu_* set, for the MIPS core.
REQ-013 SHALL have port mem_addr  output  ADDR_W  shared RAM address.
REQ-014 SHALL have port mem_wr_data  output  32  shared RAM write data.
REQ-015 SHALL have port mem_wr_ena  output  1  shared RAM write strobe.
REQ-016 SHALL have port mem_rd_data  input  32  shared RAM read data, one-cycle latency.

Function
REQ-017 SHALL grant at most one requester per cycle; gnt is combinational from req and registered state.
REQ-018 SHALL drive mem_addr/mem_wr_data/mem_wr_ena from the granted requester in the grant cycle; with no grant: all three 0.
REQ-019 SHALL give GPU priority when both request, unless the guard of REQ-026 forces CPU.
REQ-020 SHALL, for a granted read, assert that requester's rd_valid exactly one cycle after gnt, with rd_data = mem_rd_data; rd_data = 0 whenever rd_valid = 0.
REQ-021 SHALL not assert rd_valid for writes.
REQ-022 SHALL track owner state IDLE/GPU_RD/CPU_RD (last-cycle read grant) to route read returns; next state follows the current grant (GPU read -> GPU_RD, CPU read -> CPU_RD, write or none -> IDLE).
REQ-023 SHALL treat req held high after gnt as a new request; requesters hold addr/data stable until gnt.
REQ-024 SHALL allow back-to-back grants every cycle, including alternating requesters, with no bubble.

Reset
REQ-025 SHALL, while rstb = 0: state IDLE, run counter 0, all gnt/rd_valid 0, rd_data 0, mem_* 0; a read in flight at reset is dropped (no rd_valid after release).

Configuration
REQ-026 SHALL, with macro ARB_STARVE_GUARD_EN defined, keep a saturating run counter: +1 on each GPU grant while cpu_req = 1, cleared on CPU grant or cycle with cpu_req = 0; when counter = MAX_GPU_RUN and cpu_req = 1, grant CPU regardless of gpu_req.
REQ-027 SHALL, without ARB_STARVE_GUARD_EN, use strict GPU priority; no counter logic present.

Structure
REQ-028 SHALL place owner-state encoding (IDLE/GPU_RD/CPU_RD) and default MAX_GPU_RUN in shared package mem_arb_pkg.
REQ-029 SHALL keep the starvation counter in sub-module arb_run_counter (instantiated only under ARB_STARVE_GUARD_EN); remaining logic flat.

Verification
REQ-030 SHALL cover: CPU-only read addr 0x2000, RAM 0xDEADBEEF -> cpu_gnt cycle 0, cpu_rd_valid + 0xDEADBEEF cycle 1, gpu_* idle.
REQ-031 SHALL cover: both req read, gpu_addr 0x400, cpu_addr 0x10 -> gpu_gnt first, cpu_gnt next cycle, each rd_valid one cycle after its grant.
REQ-032 SHALL cover: guard enabled, gpu_req + cpu_req held 10 cycles, MAX_GPU_RUN=4 -> grant pattern G,G,G,G,C repeating; guard disabled -> 10 G, no C.
REQ-033 SHALL cover: GPU write 0x2000 data 5 then CPU read 0x2000 -> mem_wr_ena 1 one cycle, no gpu_rd_valid, cpu_rd_data 5.
REQ-034 SHALL cover: rstb low the cycle after a CPU read grant -> cpu_rd_valid never asserts, all outputs 0 until first grant after release.
